// File: rtl/instr_fetch_if.sv
// Shared fetch definitions plus the fetch <-> ROM/decode/execute bus.
//   instr_fetch_pkg : opcode encodings and bus widths
//   instr_fetch_if  : master = fetch unit, slave = ROM/decode/execute side
//     oAddress      ROM address (fetch PC)
//     iInstruction  ROM word for oAddress; [27:24] opcode, [23:16] target
//     iStall        decode cannot accept, hold
//     iBranchTaken  taken branch from execute, redirect and squash
//     iBranchTarget branch destination
//     iRetValid     one-cycle pulse, iRetAddr valid
//     iRetAddr      return destination
//     oInstruction  registered instruction to decode
//     oPC           address oInstruction came from
//     oLinkAddr     oPC + 1
//     oValid        oInstruction/oPC/oLinkAddr valid
//     oHalted       self-jump seen, fetch stopped
package instr_fetch_pkg;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned INSTR_W = 28;

    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
endpackage

interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic [ADDR_W-1:0]  oAddress;
    logic [INSTR_W-1:0] iInstruction;
    logic               iStall;
    logic               iBranchTaken;
    logic [ADDR_W-1:0]  iBranchTarget;
    logic               iRetValid;
    logic [ADDR_W-1:0]  iRetAddr;
    logic [INSTR_W-1:0] oInstruction;
    logic [ADDR_W-1:0]  oPC;
    logic [ADDR_W-1:0]  oLinkAddr;
    logic               oValid;
    logic               oHalted;

    modport master (
        output oAddress, oInstruction, oPC, oLinkAddr, oValid, oHalted,
        input  iInstruction, iStall, iBranchTaken, iBranchTarget, iRetValid, iRetAddr
    );

    modport slave (
        input  oAddress, oInstruction, oPC, oLinkAddr, oValid, oHalted,
        output iInstruction, iStall, iBranchTaken, iBranchTarget, iRetValid, iRetAddr
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: boots, walks the ROM, resolves JMP/CALL in fetch,
// parks on RET until the return address arrives, and stops on a self-jump.
//   Clock : rising-edge clock
//   Reset : synchronous active-low reset
//   bus   : instr_fetch_if.master (ROM address/word, decode outputs,
//           stall, branch redirect, return address)
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [3:0]  P_OP_JMP      = OP_JMP,
    parameter logic [3:0]  P_OP_CALL     = OP_CALL,
    parameter logic [3:0]  P_OP_RET      = OP_RET,
    parameter int unsigned P_BOOT_CYCLES = 4
) (
    input  logic          Clock,
    input  logic          Reset,
    instr_fetch_if.master bus
);

    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_WAIT_RET,
        ST_HALT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  opc_q, opc_d;
    logic [ADDR_W-1:0]  link_q, link_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;

    logic [3:0]         opcode;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  pc_inc;

    // State and output registers
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= ST_BOOT;
            cnt_q    <= '0;
            pc_q     <= '0;
            instr_q  <= '0;
            opc_q    <= '0;
            link_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            opc_q    <= opc_d;
            link_q   <= link_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    // Next-state, PC and decode-register update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        opc_d    = opc_q;
        link_d   = link_q;
        valid_d  = valid_q;
        halted_d = halted_q;

        opcode = bus.iInstruction[27:24];
        target = {8'h00, bus.iInstruction[23:16]};
        pc_inc = ADDR_W'(pc_q + 16'd1);

        case (state_q)
            ST_BOOT: begin
                valid_d = 1'b0;
                if ((32'(cnt_q) + 32'd1) >= P_BOOT_CYCLES) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 5'd1);
                end
            end

            ST_RUN: begin
                if (bus.iBranchTaken) begin
                    pc_d    = bus.iBranchTarget;
                    valid_d = 1'b0;
                end else if (!bus.iStall) begin
                    if (opcode == P_OP_JMP) begin
                        // JMP is consumed here; a jump to itself can never progress
                        valid_d = 1'b0;
                        if (target == pc_q) begin
                            state_d  = ST_HALT;
                            halted_d = 1'b1;
                        end else begin
                            pc_d = target;
                        end
                    end else begin
                        instr_d = bus.iInstruction;
                        opc_d   = pc_q;
                        link_d  = pc_inc;
                        valid_d = 1'b1;
                        if (opcode == P_OP_CALL) begin
                            pc_d = target;
                        end else if (opcode == P_OP_RET) begin
                            state_d = ST_WAIT_RET;
                        end else begin
                            pc_d = pc_inc;
                        end
                    end
                end
            end

            ST_WAIT_RET: begin
                if (bus.iBranchTaken) begin
                    pc_d    = bus.iBranchTarget;
                    valid_d = 1'b0;
                    state_d = ST_RUN;
                end else if (!bus.iStall) begin
                    // RET stays visible to decode until it is accepted
                    valid_d = 1'b0;
                    if (bus.iRetValid) begin
                        pc_d    = bus.iRetAddr;
                        state_d = ST_RUN;
                    end
                end
            end

            ST_HALT: begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign bus.oAddress     = pc_q;
    assign bus.oInstruction = instr_q;
    assign bus.oPC          = opc_q;
    assign bus.oLinkAddr    = link_q;
    assign bus.oValid       = valid_q;
    assign bus.oHalted      = halted_q;

endmodule
